fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 8-bit microprocessor.
- Sequences the 16-bit program counter through its control pins:
  - Inc pulses step the PC.
  - For LD, the low byte is presented with LD high; the high byte is presented on the next cycle with LD low.
- Also drives memory reads, latches the opcode into the instruction register, fetches 2-byte jump operands and hands non-jump instructions to the execute datapath via a start/done handshake.

Parameters:
- OP_JMP, 8'hC0, opcode of unconditional absolute jump (2 operand bytes, low first).
- OP_JZ, 8'hC1, opcode of jump-if-zero (2 operand bytes, low first).
- OP_HLT, 8'hFF, opcode of halt.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  start request; sampled only in IDLE.
- mem_rdata  in  8  memory read data; valid the cycle after mem_rd (address = PCout, driven externally).
- zero_flag  in  1  ALU zero flag; sampled in WAIT_HI.
- exec_done  in  1  execute datapath finished current instruction.
- mem_rd  out  1  memory read strobe.
- pc_inc  out  1  to PC Inc.
- pc_ld  out  1  to PC LD.
- pc_bus  out  8  byte to PC PCin.
- ir  out  8  instruction register.
- exec_start  out  1  one-cycle pulse starting execute.
- halted  out  1  high in HALT state.

Behaviour:
- Reset state and outputs:
  - rst_n=0 at a rising edge: state -> IDLE; ir, addr_lo, addr_hi and pc_bus -> 0.
  - All strobes are 0 in reset and in IDLE.
  - Reset is honoured in every state, including mid-jump-load and mid-EXEC. A jump load abandoned by reset is not completed.
- State machine (one state per cycle unless noted):
  - IDLE: stay until run=1 -> FETCH_OP.
  - FETCH_OP: mem_rd=1 -> WAIT_OP.
  - WAIT_OP: ir<=mem_rdata; pc_inc=1 -> DECODE.
  - DECODE (no strobes):
    - ir==OP_JMP or OP_JZ -> FETCH_LO.
    - ir==OP_HLT -> HALT.
    - else -> EXEC.
  - FETCH_LO: mem_rd=1 -> WAIT_LO.
  - WAIT_LO: addr_lo<=mem_rdata; pc_inc=1 -> FETCH_HI.
  - FETCH_HI: mem_rd=1 -> WAIT_HI.
  - WAIT_HI: addr_hi<=mem_rdata; pc_inc=1.
    - Taken = (ir==OP_JMP) or (ir==OP_JZ and zero_flag=1).
    - Taken -> JLD_LO; not taken -> FETCH_OP.
  - JLD_LO: pc_ld=1, pc_bus=addr_lo -> JLD_HI.
  - JLD_HI: pc_ld=0, pc_bus=addr_hi -> FETCH_OP.
    - pc_ld must be 0 here so the PC does not restart its load.
  - EXEC:
    - exec_start=1 only on the first EXEC cycle.
    - exec_done is sampled from that first cycle onward; exec_done=1 -> FETCH_OP, else stay.
    - exec_done arriving in the same cycle as exec_start is accepted.
  - HALT: halted=1; pc_inc, pc_ld and mem_rd stay 0. Exits only via reset; run is ignored.
- Strobe rules:
  - pc_inc and pc_ld are never high in the same cycle.
  - pc_inc is high only in WAIT_* states.
  - pc_bus holds its last value outside JLD_*.
- Latency:
  - Non-jump instruction: 4 cycles + execute wait.
  - Taken jump: 9 cycles.
  - Not-taken JZ: 7 cycles.
- Jump targets: no arithmetic on the target; addr_hi:addr_lo is passed unchanged. PC wrap-around 16'hFFFF->16'h0000 is owned by the PC.
- exec_done outside EXEC is ignored.

Decomposition:
- fetch_pkg holds:
  - the state enum (IDLE, FETCH_OP, WAIT_OP, DECODE, FETCH_LO, WAIT_LO, FETCH_HI, WAIT_HI, JLD_LO, JLD_HI, EXEC, HALT; 4-bit);
  - default opcode constants.
- Single module, no sub-module; the next-state/output logic and operand registers are small enough to live together.
- The bench instantiates fetch_sequencer with the existing 16-bit program counter and a behavioural 1-cycle-latency ROM.

Test Plan:
- Reset/start: hold rst_n=0 2 cycles, then run=1 with ROM[0]=8'h01.
  - All strobes 0 during reset.
  - mem_rd at cycle 1 after run; ir=8'h01; exec_start single pulse.
  - With exec_done returned 3 cycles later, the next mem_rd occurs with PC=1.
- JMP: ROM[0..2]=C0,34,12.
  - pc_inc pulses at PC 0,1,2.
  - pc_ld=1 with pc_bus=34, next cycle pc_ld=0 with pc_bus=12.
  - Next fetch at PC=16'h1234, 9 cycles after first fetch.
- JZ not taken: ROM[0..2]=C1,00,80, zero_flag=0.
  - No pc_ld; next fetch at PC=3.
  - Same stimulus with zero_flag=1 -> next fetch at 16'h8000.
- HLT: ROM[0]=FF.
  - halted=1 from cycle after DECODE; mem_rd, pc_inc and exec_start stay 0 for 20 cycles despite run=1.
  - rst_n=0 returns to IDLE with halted=0.
- Reset mid-operation and immediate done:
  - Assert rst_n=0 during JLD_LO -> next cycle IDLE, pc_ld=0, ir=0.
  - exec_done=1 in the same cycle as exec_start -> FETCH_OP on the following cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default opcodes for the fetch sequencer
package fetch_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH_OP, WAIT_OP, DECODE, FETCH_LO, WAIT_LO,
    FETCH_HI, WAIT_HI, JLD_LO, JLD_HI, EXEC, HALT
  } state_t;
  localparam logic [7:0] DEF_OP_JMP = 8'hC0;
  localparam logic [7:0] DEF_OP_JZ  = 8'hC1;
  localparam logic [7:0] DEF_OP_HLT = 8'hFF;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: memory, program-counter and execute handshake signals of the fetch sequencer
interface fetch_sequencer_if;
  logic       run;
  logic       zero_flag;
  logic       exec_done;
  logic [7:0] mem_rdata;
  logic       mem_rd;
  logic       pc_inc;
  logic       pc_ld;
  logic [7:0] pc_bus;
  logic [7:0] ir;
  logic       exec_start;
  logic       halted;
  modport master (
    input  run, zero_flag, exec_done, mem_rdata,
    output mem_rd, pc_inc, pc_ld, pc_bus, ir, exec_start, halted
  );
  modport slave (
    output run, zero_flag, exec_done, mem_rdata,
    input  mem_rd, pc_inc, pc_ld, pc_bus, ir, exec_start, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: steps the PC, fetches opcodes and jump operands, and hands other opcodes to execute
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [7:0] OP_JMP = DEF_OP_JMP,
  parameter logic [7:0] OP_JZ  = DEF_OP_JZ,
  parameter logic [7:0] OP_HLT = DEF_OP_HLT
) (
  input logic clk,
  input logic rst_n,
  fetch_sequencer_if.master bus
);
  state_t state, state_n;
  logic [7:0] addr_lo, addr_hi;
  logic first;
  logic jump, taken;
  assign jump  = bus.ir == OP_JMP || bus.ir == OP_JZ;
  assign taken = bus.ir == OP_JMP || (bus.ir == OP_JZ && bus.zero_flag);
  // next state and state-decoded strobes, all forced low while reset is held
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = bus.run ? FETCH_OP : IDLE;
      FETCH_OP: state_n = WAIT_OP;
      WAIT_OP:  state_n = DECODE;
      DECODE:   state_n = jump ? FETCH_LO : bus.ir == OP_HLT ? HALT : EXEC;
      FETCH_LO: state_n = WAIT_LO;
      WAIT_LO:  state_n = FETCH_HI;
      FETCH_HI: state_n = WAIT_HI;
      WAIT_HI:  state_n = taken ? JLD_LO : FETCH_OP;
      JLD_LO:   state_n = JLD_HI;
      JLD_HI:   state_n = FETCH_OP;
      EXEC:     state_n = bus.exec_done ? FETCH_OP : EXEC;
      HALT:     state_n = HALT;
      default:  state_n = IDLE;
    endcase
    bus.mem_rd     = rst_n && (state == FETCH_OP || state == FETCH_LO || state == FETCH_HI);
    bus.pc_inc     = rst_n && (state == WAIT_OP || state == WAIT_LO || state == WAIT_HI);
    bus.pc_ld      = rst_n && state == JLD_LO;
    bus.exec_start = rst_n && state == EXEC && first;
    bus.halted     = rst_n && state == HALT;
  end
  // state, opcode/operand capture and the PC byte lane, which is loaded one cycle ahead of each JLD state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      first      <= 1'b0;
      bus.ir     <= '0;
      addr_lo    <= '0;
      addr_hi    <= '0;
      bus.pc_bus <= '0;
    end else begin
      state <= state_n;
      first <= state_n == EXEC && state != EXEC;
      if (state == WAIT_OP) bus.ir <= bus.mem_rdata;
      if (state == WAIT_LO) addr_lo <= bus.mem_rdata;
      if (state == WAIT_HI) addr_hi <= bus.mem_rdata;
      if (state == WAIT_HI && taken) bus.pc_bus <= addr_lo;
      if (state == JLD_LO) bus.pc_bus <= addr_hi;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with a 16-bit PC model, 1-cycle ROM and program-level reference model
module tb_fetch_sequencer;
  import fetch_pkg::*;
  localparam int K_RD = 0, K_LD = 1, K_EX = 2, K_HLT = 3;
  typedef struct {int k; logic [15:0] v;} ev_t;
  logic clk = 1'b0;
  logic rst_n;
  fetch_sequencer_if f();
  fetch_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(f));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  ev_t q[$];
  int rd_times[$];
  logic [7:0] rom [0:65535];
  logic [15:0] pc;
  logic [7:0] lo_q;
  logic pend;
  logic hi_due, halt_seen;
  logic [7:0] hi_exp;
  logic [15:0] v;
  int halt_cyc;
  int dly, dly_min, dly_max;
  bit noise_en;
  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h at cycle %0d", nm, got, exp, cyc);
    end
  endfunction
  function automatic void push(input int k, input logic [15:0] val);
    ev_t e;
    e.k = k;
    e.v = val;
    q.push_back(e);
  endfunction
  task automatic pop_ev(input int k, output logic [15:0] val);
    ev_t e;
    e.k = -1;
    e.v = '0;
    if (q.size() != 0) e = q.pop_front();
    chk("event_kind", e.k, k);
    val = e.v;
  endtask
  always @(posedge clk) cyc++;
  // program counter: Inc steps, LD high takes the low byte, the following LD-low cycle takes the high byte
  always @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
      pend <= 1'b0;
    end else if (f.pc_ld) begin
      lo_q <= f.pc_bus;
      pend <= 1'b1;
    end else if (pend) begin
      pc <= {f.pc_bus, lo_q};
      pend <= 1'b0;
    end else if (f.pc_inc) pc <= pc + 16'd1;
  end
  always @(posedge clk) f.mem_rdata <= rom[pc];
  // execute datapath stand-in: done after a random delay, random noise on exec_done while nothing executes
  always @(negedge clk) begin
    if (!rst_n) begin
      dly = -1;
      f.exec_done = 1'b0;
    end else begin
      if (f.exec_start) dly = int'($urandom_range(dly_max, dly_min));
      if (dly == 0) begin
        f.exec_done = 1'b1;
        dly = -1;
      end else begin
        if (dly > 0) dly--;
        f.exec_done = (noise_en && dly < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end
  // monitor: every observable event pops the scoreboard in order
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      rd_times.delete();
      hi_due = 1'b0;
      halt_seen = 1'b0;
    end else begin
      if (hi_due) begin
        chk("ld_hi_bus", {f.pc_ld, f.pc_bus}, {1'b0, hi_exp});
        hi_due = 1'b0;
      end
      if (f.pc_inc || f.pc_ld) chk("inc_ld_excl", f.pc_inc & f.pc_ld, 0);
      if (f.mem_rd) begin
        pop_ev(K_RD, v);
        chk("fetch_addr", pc, v);
        rd_times.push_back(cyc);
      end
      if (f.pc_ld) begin
        pop_ev(K_LD, v);
        chk("ld_lo_bus", f.pc_bus, v[7:0]);
        hi_exp = v[15:8];
        hi_due = 1'b1;
      end
      if (f.exec_start) begin
        pop_ev(K_EX, v);
        chk("exec_ir", f.ir, v[7:0]);
      end
      if (f.halted && !halt_seen) begin
        pop_ev(K_HLT, v);
        halt_seen = 1'b1;
        halt_cyc = cyc;
      end
      if (f.halted) chk("halt_quiet", {f.mem_rd, f.pc_inc, f.pc_ld, f.exec_start}, 0);
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    f.run = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_strobes", {f.mem_rd, f.pc_inc, f.pc_ld, f.exec_start, f.halted}, 0);
      chk("rst_ir", f.ir, 0);
      chk("rst_bus", f.pc_bus, 0);
    end
    rst_n = 1'b1;
  endtask
  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !halt_seen; i++) @(negedge clk);
    @(negedge clk);
    chk("halt_reached", halt_seen, 1);
    chk("queue_empty", q.size(), 0);
  endtask
  task automatic chk_gap(input string nm, input int k, input int n);
    chk(nm, rd_times.size() > k ? rd_times[k] - rd_times[0] : -1, n);
  endtask
  // reference model: walks the program by instruction semantics, writing ROM and expected events
  task automatic gen_program(input int n, input bit zf);
    logic [15:0] p, t;
    logic [7:0] op;
    int seg, pg, r;
    bit used [256];
    foreach (used[i]) used[i] = 1'b0;
    used[0] = 1'b1;
    p = '0;
    seg = 0;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      op = (i == n - 1) ? DEF_OP_HLT : (seg >= 20 || r == 0) ? DEF_OP_JMP :
           r == 1 ? DEF_OP_JZ : 8'($urandom_range(0, 8'hBF));
      rom[p] = op;
      push(K_RD, p);
      p++;
      if (op == DEF_OP_JMP || op == DEF_OP_JZ) begin
        if (op == DEF_OP_JMP || zf) begin
          do pg = int'($urandom_range(1, 255)); while (used[pg]);
          used[pg] = 1'b1;
          t = {8'(pg), 1'b0, 7'($urandom_range(0, 127))};
        end else t = 16'($urandom);
        rom[p] = t[7:0];
        push(K_RD, p);
        p++;
        rom[p] = t[15:8];
        push(K_RD, p);
        p++;
        if (op == DEF_OP_JMP || zf) begin
          push(K_LD, t);
          p = t;
          seg = 0;
        end else seg++;
      end else if (op == DEF_OP_HLT) push(K_HLT, 0);
      else begin
        push(K_EX, {8'h00, op});
        seg++;
      end
    end
  endtask
  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = 8'h00;
    rst_n = 1'b0;
    f.run = 1'b0;
    f.zero_flag = 1'b0;
    dly_min = 3;
    dly_max = 3;
    noise_en = 1'b0;
    rom[0] = 8'h01;
    rom[1] = 8'hFF;
    do_reset();
    push(K_RD, 0); push(K_EX, 16'h01); push(K_RD, 1); push(K_HLT, 0);
    f.run = 1'b1;
    @(negedge clk);
    chk("start_rd", f.mem_rd, 1);
    wait_halt(200);
    chk_gap("nonjump_lat", 1, 7);
    chk("halt_lat", rd_times.size() > 0 ? halt_cyc - rd_times[rd_times.size() - 1] : -1, 3);
    repeat (20) @(negedge clk);
    chk("halt_hold", f.halted, 1);
    rom[0] = 8'hC0; rom[1] = 8'h34; rom[2] = 8'h12; rom[16'h1234] = 8'hFF;
    do_reset();
    push(K_RD, 0); push(K_RD, 1); push(K_RD, 2); push(K_LD, 16'h1234); push(K_RD, 16'h1234); push(K_HLT, 0);
    f.run = 1'b1;
    wait_halt(200);
    chk_gap("jmp_lat", 3, 9);
    rom[0] = 8'hC1; rom[1] = 8'h00; rom[2] = 8'h80; rom[3] = 8'hFF; rom[16'h8000] = 8'hFF;
    do_reset();
    push(K_RD, 0); push(K_RD, 1); push(K_RD, 2); push(K_RD, 3); push(K_HLT, 0);
    f.run = 1'b1;
    wait_halt(200);
    chk_gap("jz_nt_lat", 3, 7);
    do_reset();
    f.zero_flag = 1'b1;
    push(K_RD, 0); push(K_RD, 1); push(K_RD, 2); push(K_LD, 16'h8000); push(K_RD, 16'h8000); push(K_HLT, 0);
    f.run = 1'b1;
    wait_halt(200);
    chk_gap("jz_t_lat", 3, 9);
    f.zero_flag = 1'b0;
    rom[0] = 8'hC0; rom[1] = 8'h34; rom[2] = 8'h12;
    do_reset();
    push(K_RD, 0); push(K_RD, 1); push(K_RD, 2); push(K_LD, 16'h1234);
    f.run = 1'b1;
    for (int i = 0; i < 20 && !f.pc_ld; i++) @(negedge clk);
    chk("jld_reached", f.pc_ld, 1);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("idle_quiet", {f.mem_rd, f.pc_ld, f.pc_bus}, 0);
    end
    push(K_RD, 0); push(K_RD, 1); push(K_RD, 2); push(K_LD, 16'h1234); push(K_RD, 16'h1234); push(K_HLT, 0);
    f.run = 1'b1;
    wait_halt(200);
    rom[0] = 8'h01; rom[1] = 8'hFF;
    dly_min = 0;
    dly_max = 0;
    do_reset();
    push(K_RD, 0); push(K_EX, 16'h01); push(K_RD, 1); push(K_HLT, 0);
    f.run = 1'b1;
    wait_halt(200);
    chk_gap("done_same_cycle", 1, 4);
    dly_min = 0;
    dly_max = 3;
    for (int zf = 0; zf < 2; zf++) begin
      do_reset();
      f.zero_flag = 1'(zf);
      gen_program(60, 1'(zf));
      noise_en = 1'b1;
      f.run = 1'b1;
      wait_halt(4000);
      noise_en = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
